// File: rtl/down_count_monitor.sv
// down_count_monitor
//
// Watches the output of a free-running W-bit down counter and checks that each
// accepted sample is exactly one less (mod 2^W) than the previous one. After
// LOCK_N consecutive good steps the monitor locks. While locked it pulses on
// every 0 -> max wrap, counts wraps, and counts sequence errors. Any error
// drops the monitor back to acquisition.
//
// Ports
//   clk        in   clock
//   rst        in   asynchronous active-high reset
//   cnt_in     in   [W-1:0] count value from the upstream down counter
//   cnt_valid  in   sample cnt_in on this edge
//   clr        in   synchronous clear of all state; wins over cnt_valid
//   locked     out  monitor is in the locked state
//   wrap_pulse out  one-cycle pulse for a wrap accepted while locked
//   wrap_count out  [WRAP_CW-1:0] accepted wraps, saturating
//   seq_err    out  sticky flag, set on the first mismatch while locked
//   err_count  out  [ERR_CW-1:0] mismatches while locked, saturating
//   at_zero    out  last accepted sample was zero
module down_count_monitor #(
  parameter int unsigned W       = 4,
  parameter int unsigned LOCK_N  = 4,
  parameter int unsigned WRAP_CW = 8,
  parameter int unsigned ERR_CW  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [W-1:0]       cnt_in,
  input  logic               cnt_valid,
  input  logic               clr,
  output logic               locked,
  output logic               wrap_pulse,
  output logic [WRAP_CW-1:0] wrap_count,
  output logic               seq_err,
  output logic [ERR_CW-1:0]  err_count,
  output logic               at_zero
);

  // LOCK_N is limited to 1..15, so four bits always hold the run length.
  localparam int unsigned GoodW = 4;

  typedef enum logic [1:0] {
    StInit,
    StAcquire,
    StLocked
  } state_e;

  state_e             state_q, state_d;
  logic [W-1:0]       prev_q, prev_d;
  logic [GoodW-1:0]   good_q, good_d;
  logic               wrap_pulse_q, wrap_pulse_d;
  logic [WRAP_CW-1:0] wrap_cnt_q, wrap_cnt_d;
  logic               seq_err_q, seq_err_d;
  logic [ERR_CW-1:0]  err_cnt_q, err_cnt_d;
  logic               at_zero_q, at_zero_d;

  logic [W-1:0] expected;
  logic         match;

  // Natural W-bit wraparound gives the modulo-2^W decrement.
  assign expected = prev_q - W'(1);
  assign match    = (cnt_in == expected);

  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    good_d       = good_q;
    wrap_pulse_d = 1'b0;
    wrap_cnt_d   = wrap_cnt_q;
    seq_err_d    = seq_err_q;
    err_cnt_d    = err_cnt_q;
    at_zero_d    = at_zero_q;

    if (clr) begin
      state_d    = StInit;
      prev_d     = '0;
      good_d     = '0;
      wrap_cnt_d = '0;
      seq_err_d  = 1'b0;
      err_cnt_d  = '0;
      at_zero_d  = 1'b0;
    end else if (cnt_valid) begin
      prev_d    = cnt_in;
      at_zero_d = (cnt_in == '0);
      unique case (state_q)
        StInit: begin
          // First sample only seeds prev; there is nothing to compare against.
          state_d = StAcquire;
          good_d  = '0;
        end
        StAcquire: begin
          if (match) begin
            if (good_q == GoodW'(LOCK_N - 1)) begin
              state_d = StLocked;
              good_d  = '0;
            end else begin
              good_d = good_q + GoodW'(1);
            end
          end else begin
            good_d = '0;
          end
        end
        StLocked: begin
          if (match) begin
            // A matching step out of zero is the wrap to all-ones.
            if (prev_q == '0) begin
              wrap_pulse_d = 1'b1;
              if (wrap_cnt_q != '1) wrap_cnt_d = wrap_cnt_q + WRAP_CW'(1);
            end
          end else begin
            state_d   = StAcquire;
            good_d    = '0;
            seq_err_d = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_CW'(1);
          end
        end
        default: begin
          state_d = StInit;
          good_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StInit;
      prev_q       <= '0;
      good_q       <= '0;
      wrap_pulse_q <= 1'b0;
      wrap_cnt_q   <= '0;
      seq_err_q    <= 1'b0;
      err_cnt_q    <= '0;
      at_zero_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      good_q       <= good_d;
      wrap_pulse_q <= wrap_pulse_d;
      wrap_cnt_q   <= wrap_cnt_d;
      seq_err_q    <= seq_err_d;
      err_cnt_q    <= err_cnt_d;
      at_zero_q    <= at_zero_d;
    end
  end

  assign locked     = (state_q == StLocked);
  assign wrap_pulse = wrap_pulse_q;
  assign wrap_count = wrap_cnt_q;
  assign seq_err    = seq_err_q;
  assign err_count  = err_cnt_q;
  assign at_zero    = at_zero_q;

endmodule

// File: tb/tb_down_count_monitor.sv
// Bench for down_count_monitor. Two instances share the stimulus: one with
// default parameters and one with a 2-bit wrap counter to exercise saturation.
// Expected values come from a sample-level model of the monitoring rules.
module tb_down_count_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] cnt_in = 4'd0;
  logic       cnt_valid = 1'b0;
  logic       clr = 1'b0;

  logic       locked, wrap_pulse, seq_err, at_zero;
  logic [7:0] wrap_count;
  logic [3:0] err_count;

  logic       s_locked, s_wrap_pulse, s_seq_err, s_at_zero;
  logic [1:0] s_wrap_count;
  logic [3:0] s_err_count;

  down_count_monitor dut (
    .clk        (clk),
    .rst        (rst),
    .cnt_in     (cnt_in),
    .cnt_valid  (cnt_valid),
    .clr        (clr),
    .locked     (locked),
    .wrap_pulse (wrap_pulse),
    .wrap_count (wrap_count),
    .seq_err    (seq_err),
    .err_count  (err_count),
    .at_zero    (at_zero)
  );

  down_count_monitor #(
    .WRAP_CW (2)
  ) dut_s (
    .clk        (clk),
    .rst        (rst),
    .cnt_in     (cnt_in),
    .cnt_valid  (cnt_valid),
    .clr        (clr),
    .locked     (s_locked),
    .wrap_pulse (s_wrap_pulse),
    .wrap_count (s_wrap_count),
    .seq_err    (s_seq_err),
    .err_count  (s_err_count),
    .at_zero    (s_at_zero)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int pulses = 0;
  int up = 0;

  // Reference model: last sample, whether one has been seen, current run of
  // correct steps, lock flag and the observable counters.
  int m_prev, m_seen, m_run, m_lock, m_wraps, m_errs, m_seq, m_pulse, m_zero;

  task automatic model_reset();
    m_prev = 0; m_seen = 0; m_run = 0; m_lock = 0;
    m_wraps = 0; m_errs = 0; m_seq = 0; m_pulse = 0; m_zero = 0;
  endtask

  task automatic model_sample(input int v);
    bit good;
    good    = (v == (m_prev + 15) % 16);
    m_pulse = 0;
    if (m_seen == 0) begin
      m_seen = 1;
      m_run  = 0;
    end else if (m_lock != 0) begin
      if (good) begin
        if (v == 15) begin
          m_pulse = 1;
          m_wraps++;
        end
      end else begin
        m_lock = 0;
        m_run  = 0;
        m_seq  = 1;
        if (m_errs < 15) m_errs++;
      end
    end else begin
      if (good) begin
        m_run++;
        if (m_run == 4) begin
          m_lock = 1;
          m_run  = 0;
        end
      end else begin
        m_run = 0;
      end
    end
    m_prev = v;
    m_zero = (v == 0);
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("locked", int'(locked), m_lock);
    chk("wrap_pulse", int'(wrap_pulse), m_pulse);
    chk("wrap_count", int'(wrap_count), (m_wraps > 255) ? 255 : m_wraps);
    chk("seq_err", int'(seq_err), m_seq);
    chk("err_count", int'(err_count), m_errs);
    chk("at_zero", int'(at_zero), m_zero);
    chk("s_locked", int'(s_locked), m_lock);
    chk("s_wrap_pulse", int'(s_wrap_pulse), m_pulse);
    chk("s_wrap_count", int'(s_wrap_count), (m_wraps > 3) ? 3 : m_wraps);
    chk("s_err_count", int'(s_err_count), m_errs);
    if (wrap_pulse === 1'b1) pulses++;
  endtask

  // Drive between edges, let one rising edge sample, check 1 time unit later.
  task automatic step(input bit v, input bit c, input int val);
    @(negedge clk);
    cnt_valid = v;
    clr       = c;
    cnt_in    = val[3:0];
    @(posedge clk);
    if (c) model_reset();
    else if (v) model_sample(val);
    else m_pulse = 0;
    if (v && !c) up = val;
    #1;
    check_all();
  endtask

  task automatic feed(input int val);
    step(1'b1, 1'b0, val);
  endtask

  task automatic feed_down(input int start, input int n);
    for (int i = 0; i < n; i++) feed(((start - i) % 16 + 16) % 16);
  endtask

  // Reset asserted between clock edges; outputs must clear without an edge.
  task automatic async_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  int p0;
  bit rv, rc;
  int rval;

  initial begin
    model_reset();
    #12;
    check_all();
    rst = 1'b0;

    // Lock on 15..11, run down to 0, then wrap.
    feed_down(15, 5);
    chk("lock_after_11", int'(locked), 1);
    feed_down(10, 11);
    chk("at_zero_after_0", int'(at_zero), 1);
    feed(15);
    chk("first_wrap_pulse", int'(wrap_pulse), 1);
    chk("first_wrap_count", int'(wrap_count), 1);
    feed(14);
    chk("wrap_pulse_one_cycle", int'(wrap_pulse), 0);

    // Mismatch while locked at 7, then relock on 8,7,6,5.
    feed_down(13, 7);
    feed(9);
    chk("mismatch_unlock", int'(locked), 0);
    chk("mismatch_err", int'(err_count), 1);
    feed_down(8, 4);
    chk("relock", int'(locked), 1);
    chk("seq_err_sticky", int'(seq_err), 1);

    // Gapped sampling: invalid cycles carry junk, then 4,3 continue from 5.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, int'($urandom % 16));
    up = 5;
    feed_down(4, 2);
    chk("gap_locked", int'(locked), 1);
    chk("gap_no_err", int'(err_count), 1);

    // Five full wraps; 2-bit counter sticks at 3.
    p0 = pulses;
    feed_down(2, 80);
    chk("five_pulses", pulses - p0, 5);
    chk("sat_wrap2", int'(s_wrap_count), 3);

    // Seventeen more errors, relocking after each; 4-bit counter sticks at 15.
    for (int i = 0; i < 17; i++) begin
      rval = (up + 8) % 16;
      feed(rval);
      feed_down((rval + 15) % 16, 4);
    end
    chk("sat_err", int'(err_count), 15);

    // Clear wins over a valid sample of 0.
    step(1'b1, 1'b1, 0);
    chk("clr_locked", int'(locked), 0);
    chk("clr_wraps", int'(wrap_count), 0);
    chk("clr_at_zero", int'(at_zero), 0);

    // Asynchronous reset mid-stream.
    feed_down(15, 7);
    async_reset();
    chk("rst_locked", int'(locked), 0);

    // Held value and upstream restart to 15.
    feed_down(15, 10);
    feed(6);
    chk("held_err", int'(err_count), 1);
    feed_down(5, 19);
    feed(15);
    chk("restart_err", int'(err_count), 2);
    feed_down(14, 15);
    feed(15);
    chk("zero_to_15_wrap", int'(wrap_pulse), 1);
    chk("zero_to_15_no_err", int'(err_count), 2);

    // Random gaps, clears and corrupted samples against the model.
    for (int i = 0; i < 2000; i++) begin
      rv   = ($urandom % 4) != 0;
      rc   = ($urandom % 64) == 0;
      rval = (($urandom % 8) == 0) ? int'($urandom % 16) : (up + 15) % 16;
      step(rv, rc, rval);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/down_count_monitor.md
Name: down_count_monitor

Overview:
Downstream consumer of the free-running 4-bit down counter (resets to 15, decrements by 1 per clock). It samples the count stream and checks that every step is exactly a decrement of 1, modulo 2^W. It locks after a run of good steps, then flags wrap events (0 -> max), counts wraps and sequence errors, and reports lock status. Status is used by system control and by debug counters.

Parameters:
W, 4, width of monitored count.
LOCK_N, 4, consecutive correct decrements required to reach LOCKED (range 1..15).
WRAP_CW, 8, width of wrap_count (saturating).
ERR_CW, 4, width of err_count (saturating).

Ports:
clk  in  1  clock.
rst  in  1  reset, asynchronous, active-high.
cnt_in  in  W  count value from the upstream down counter.
cnt_valid  in  1  sample cnt_in on this clk edge; tie high for every-cycle monitoring.
clr  in  1  synchronous clear of state, counters and sticky flag; overrides cnt_valid.
locked  out  1  high while FSM is in LOCKED.
wrap_pulse  out  1  single-cycle pulse when a wrap is accepted in LOCKED.
wrap_count  out  WRAP_CW  number of accepted wraps, saturating.
seq_err  out  1  sticky: set on the first mismatch seen in LOCKED.
err_count  out  ERR_CW  number of mismatches seen in LOCKED, saturating.
at_zero  out  1  last accepted sample equals 0.

Behaviour:
- Registers and outputs:
  - All outputs are registered and update on the clk edge that samples cnt_in.
  - Latency is 1: the response is visible in the cycle after the sampling edge.
- rst (async, any time, including mid-stream):
  - state=INIT; prev=0; good_cnt=0.
  - locked=0, wrap_pulse=0, wrap_count=0, seq_err=0, err_count=0, at_zero=0.
- clr=1 at a clk edge: same values as rst, applied synchronously; cnt_in is ignored on that edge.
- No cnt_valid: with cnt_valid=0 and clr=0, all state holds and wrap_pulse=0.
- On a sample (cnt_valid=1, clr=0):
  - expected = (prev - 1) mod 2^W.
  - match = (cnt_in == expected).
  - prev <= cnt_in in every state.
  - at_zero <= (cnt_in == 0).
- FSM states: INIT, ACQUIRE, LOCKED.
  - INIT, on a sample: no check is made; go to ACQUIRE with good_cnt=0.
  - ACQUIRE, on a sample:
    - match: good_cnt+1; if it reaches LOCK_N, go to LOCKED (locked=1 the next cycle) and clear good_cnt.
    - mismatch: good_cnt=0; stay in ACQUIRE.
    - Errors and wraps are not counted in ACQUIRE.
  - LOCKED, on a sample:
    - match with prev==0 (cnt_in == 2^W-1): wrap_pulse=1 for one cycle; wrap_count+1, saturating at all-ones.
    - mismatch: go to ACQUIRE with good_cnt=0; locked=0 the next cycle; seq_err=1; err_count+1, saturating.
    - A held value (cnt_in==prev) is a mismatch.
    - An upstream reset to 15 from any prev other than 0 is a mismatch.
- Simultaneous events:
  - clr has priority over a sample.
  - A wrap and a mismatch cannot coincide.
  - Wraps observed in ACQUIRE never pulse.
- Arithmetic:
  - All count comparisons are modulo 2^W.
  - Counters saturate and never wrap.
- Steady state: wrap_pulse is never high in two consecutive cycles when cnt_valid is high every cycle and W≥2.

Test Plan:
- Lock and wrap: rst, then feed 15,14,13,12,11 with cnt_valid=1 each cycle -> locked=1 in the cycle after sample 11. Continue to 0, then 15 -> wrap_pulse high exactly one cycle; wrap_count=1; at_zero=1 in the cycle after sample 0.
- Mismatch in LOCKED: locked stream at 7, then inject 9 -> locked=0, seq_err=1, err_count=1. Then feed 8,7,6,5 -> relock after 5; seq_err stays 1.
- Saturation: WRAP_CW=2, locked, run 5 full wraps -> wrap_count=3 and holds at 3; 5 wrap_pulses observed. Injecting 17 errors with ERR_CW=4 -> err_count=15.
- Gapped sampling: locked stream, cnt_valid low for 3 cycles while cnt_in changes arbitrarily, then valid samples 4,3 following last accepted 5 -> no error, locked stays 1.
- Clear and reset priority: locked with counters nonzero, assert clr with cnt_valid=1 and cnt_in=0 -> all outputs 0, state INIT, wrap not counted. Separately, assert rst asynchronously mid-cycle -> outputs 0 immediately, without waiting for a clk edge.
- Held value and upstream reset: locked at 6, feed 6 -> error. Relock, at prev=3 feed 15 -> error; at prev=0 feed 15 -> wrap_pulse, no error.
